// File: rtl/mem_fetch_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_fetch_resp_pkg
// Brief  : Shared sizes and helper types for the fetch-path memory responder.
// Rev    : 1.0  initial release
// ============================================================================
package mem_fetch_resp_pkg;

  // Default interface sizes for the fetch port
  localparam int SIZE_ADDR   = 32;
  localparam int SIZE_DATA   = 32;
  localparam int SIZE_MEMIDX = 12;

  // Request kind as carried on iw_req_we
  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;

  // Pointer width for a ring of the given depth (at least one bit)
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_fetch_resp_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module : mem_fetch_resp_rsp_fifo
// Brief  : Response queue with a registered head; push and pop may share a
//          cycle, synchronous clear drops every entry.
// Rev    : 1.0  initial release
// ============================================================================
module mem_fetch_resp_rsp_fifo
  import mem_fetch_resp_pkg::*;
#(
  parameter int P_W     = 64,
  parameter int P_DEPTH = 4
) (
  input  logic           iw_clk,
  input  logic           iw_rst_n,
  input  logic           iw_clr,
  input  logic           iw_push,
  input  logic [P_W-1:0] iw_push_data,
  input  logic           iw_pop,
  output logic           ow_valid,
  output logic [P_W-1:0] ow_data
);

  localparam int c_ptr_w = ptr_w(P_DEPTH);
  localparam int c_cnt_w = $clog2(P_DEPTH) + 1;

  logic [P_W-1:0]     r_ring [P_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_out_vld;
  logic [P_W-1:0]     r_out_data;

  logic w_out_free;
  logic w_ring_nonempty;
  logic w_load_ring;
  logic w_load_push;
  logic w_ring_wr;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(P_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Head register refills from the ring first, else straight from a push
  always_comb begin
    w_out_free      = !r_out_vld || iw_pop;
    w_ring_nonempty = (r_cnt != '0);
    w_load_ring     = w_out_free && w_ring_nonempty;
    w_load_push     = w_out_free && !w_ring_nonempty && iw_push;
    w_ring_wr       = iw_push && !w_load_push;
  end

  // Pointers, occupancy and the registered head entry
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
    end else if (iw_clr) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_out_vld <= 1'b0;
    end else begin
      if (w_ring_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_load_ring) begin
        r_rd_ptr   <= ptr_inc(r_rd_ptr);
        r_out_data <= r_ring[r_rd_ptr];
        r_out_vld  <= 1'b1;
      end else if (w_load_push) begin
        r_out_data <= iw_push_data;
        r_out_vld  <= 1'b1;
      end else if (w_out_free) begin
        r_out_vld <= 1'b0;
      end
      r_cnt <= r_cnt + c_cnt_w'(w_ring_wr) - c_cnt_w'(w_load_ring);
    end
  end

  // Ring storage needs no reset; occupancy decides what is live
  always_ff @(posedge iw_clk) begin
    if (w_ring_wr && !iw_clr) r_ring[r_wr_ptr] <= iw_push_data;
  end

  assign ow_valid = r_out_vld;
  assign ow_data  = r_out_data;

endmodule
`default_nettype wire

// File: rtl/mem_fetch_resp.sv
`default_nettype none
// ============================================================================
// Module : mem_fetch_resp
// Brief  : Fetch-port memory responder: valid/ready requests in, in-order
//          read responses out, credit-limited, flushable on redirect.
// Rev    : 1.0  initial release
// ============================================================================
module mem_fetch_resp
  import mem_fetch_resp_pkg::*;
#(
  parameter int P_ADDR_W   = SIZE_ADDR,
  parameter int P_DATA_W   = SIZE_DATA,
  parameter int P_IDX_W    = SIZE_MEMIDX,
  parameter int P_LAT      = 2,
  parameter int P_RQ_DEPTH = 4
) (
  input  logic                iw_clk,
  input  logic                iw_rst_n,
  input  logic                iw_req_valid,
  output logic                ow_req_ready,
  input  logic                iw_req_we,
  input  logic [P_ADDR_W-1:0] iw_req_addr,
  input  logic [P_DATA_W-1:0] iw_req_wdata,
  output logic                ow_rsp_valid,
  input  logic                iw_rsp_ready,
  output logic [P_DATA_W-1:0] ow_rsp_data,
  output logic [P_ADDR_W-1:0] ow_rsp_addr,
  input  logic                iw_flush,
  output logic                ow_busy
);

  localparam int                c_crd_w    = $clog2(P_RQ_DEPTH) + 1;
  localparam logic [c_crd_w-1:0] c_crd_full = c_crd_w'(P_RQ_DEPTH);

  logic                r_live;
  logic [c_crd_w-1:0]  r_credits;
  logic [c_crd_w-1:0]  w_credits_nxt;
  logic                r_busy;

  req_kind_e           w_kind;
  logic                w_acc;
  logic                w_rd_acc;
  logic                w_wr_acc;
  logic                w_pop;
  logic [P_IDX_W-1:0]  w_idx;

  logic [P_DATA_W-1:0] r_mem [2**P_IDX_W];
  logic [P_LAT-1:0]    r_pv;
  logic [P_ADDR_W-1:0] r_pa [P_LAT];
  logic [P_DATA_W-1:0] r_pd [P_LAT];

  logic                          w_fifo_vld;
  logic                          w_fifo_push;
  logic [P_ADDR_W+P_DATA_W-1:0]  w_fifo_out;

  // Accept decode; writes bypass the credit check, reads need a credit
  always_comb begin
    w_kind       = req_kind_e'(iw_req_we);
    ow_req_ready = r_live && ((w_kind == REQ_WRITE) || (r_credits != '0));
    w_acc        = iw_req_valid && ow_req_ready;
    w_wr_acc     = w_acc && (w_kind == REQ_WRITE);
    w_rd_acc     = w_acc && (w_kind == REQ_READ);
    w_idx        = iw_req_addr[P_IDX_W-1:0];
    w_pop        = w_fifo_vld && iw_rsp_ready;
    w_fifo_push  = r_pv[P_LAT-1] && !iw_flush;
  end

  // Credit bookkeeping; a flush returns everything except a same-edge read
  always_comb begin
    w_credits_nxt = r_credits;
    if (iw_flush) w_credits_nxt = c_crd_full - c_crd_w'(w_rd_acc);
    else          w_credits_nxt = r_credits + c_crd_w'(w_pop) - c_crd_w'(w_rd_acc);
  end

  // Ready gating after reset release, credit counter and busy flag
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_live    <= 1'b0;
      r_credits <= c_crd_full;
      r_busy    <= 1'b0;
    end else begin
      r_live    <= 1'b1;
      r_credits <= w_credits_nxt;
      r_busy    <= (w_credits_nxt != c_crd_full);
    end
  end

  // Read-pipe valid bits; flush kills older stages but keeps a same-edge read
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_pv <= '0;
    end else begin
      r_pv[0] <= w_rd_acc;
      for (int i = 1; i < P_LAT; i++) r_pv[i] <= iw_flush ? 1'b0 : r_pv[i-1];
    end
  end

  // Word array with synchronous read into the first pipe stage
  always_ff @(posedge iw_clk) begin
    if (w_wr_acc) r_mem[w_idx] <= iw_req_wdata;
    if (w_rd_acc) begin
      r_pa[0] <= iw_req_addr;
      r_pd[0] <= r_mem[w_idx];
    end
    for (int i = 1; i < P_LAT; i++) begin
      r_pa[i] <= r_pa[i-1];
      r_pd[i] <= r_pd[i-1];
    end
  end

  mem_fetch_resp_rsp_fifo #(
    .P_W     (P_ADDR_W + P_DATA_W),
    .P_DEPTH (P_RQ_DEPTH)
  ) u_rsp_fifo (
    .iw_clk       (iw_clk),
    .iw_rst_n     (iw_rst_n),
    .iw_clr       (iw_flush),
    .iw_push      (w_fifo_push),
    .iw_push_data ({r_pa[P_LAT-1], r_pd[P_LAT-1]}),
    .iw_pop       (w_pop),
    .ow_valid     (w_fifo_vld),
    .ow_data      (w_fifo_out)
  );

  assign ow_rsp_valid = w_fifo_vld;
  assign ow_rsp_addr  = w_fifo_out[P_ADDR_W+P_DATA_W-1:P_DATA_W];
  assign ow_rsp_data  = w_fifo_out[P_DATA_W-1:0];
  assign ow_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_fetch_resp.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_fetch_resp
// Brief  : Scoreboard bench for mem_fetch_resp (reset, streaming, stall,
//          read-after-write/alias, flush, random mix).
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_fetch_resp;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int IW  = 8;
  localparam int LAT = 2;
  localparam int D   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_we, rsp_ready, flush;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, rsp_valid, busy;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;

  // reference model state
  logic [DW-1:0]    mem_m [1<<IW];
  logic [AW+DW-1:0] sb [$];
  int               crd_m;
  bit               live_m;
  int               n_total, n_bad, n_pop;

  always #5 clk = ~clk;

  mem_fetch_resp #(
    .P_ADDR_W   (AW),
    .P_DATA_W   (DW),
    .P_IDX_W    (IW),
    .P_LAT      (LAT),
    .P_RQ_DEPTH (D)
  ) u_dut (
    .iw_clk       (clk),
    .iw_rst_n     (rst_n),
    .iw_req_valid (req_valid),
    .ow_req_ready (req_ready),
    .iw_req_we    (req_we),
    .iw_req_addr  (req_addr),
    .iw_req_wdata (req_wdata),
    .ow_rsp_valid (rsp_valid),
    .iw_rsp_ready (rsp_ready),
    .ow_rsp_data  (rsp_data),
    .ow_rsp_addr  (rsp_addr),
    .iw_flush     (flush),
    .ow_busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check, update the model, advance to next negedge
  task automatic cycle(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr, input logic fl,
                       output logic acc);
    logic exp_rdy, pop, rd;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
    rsp_ready = rr; flush = fl;
    #1;
    exp_rdy = live_m && (we || crd_m != 0);
    chk("ready", req_ready, exp_rdy);
    chk("busy", busy, crd_m != D);
    acc = v && req_ready;
    pop = rsp_valid && rr;
    if (pop) begin
      n_pop++;
      if (sb.size() == 0) chk("rsp_extra", sb.size(), 1);
      else begin
        chk("rsp", {rsp_addr, rsp_data}, sb[0]);
        void'(sb.pop_front());
      end
    end
    if (fl) sb.delete();
    rd = v && exp_rdy && !we;
    if (v && exp_rdy && we) mem_m[a[IW-1:0]] = d;
    if (rd) sb.push_back({a, mem_m[a[IW-1:0]]});
    if (fl) crd_m = D - int'(rd);
    else    crd_m = crd_m + int'(pop) - int'(rd);
    live_m = 1'b1;
    @(negedge clk);
    if (fl) chk("flush_vld", rsp_valid, 1'b0);
  endtask

  task automatic idle(input int n, input logic rr);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, rr, 1'b0, acc);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 40 && sb.size() != 0; i++) cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("drain_empty", sb.size(), 0);
    idle(3, 1'b1);
  endtask

  // Called at a negedge; asserts reset through one edge, checks, releases
  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; rsp_ready = 1'b1; flush = 1'b0;
    #2;
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_vld", rsp_valid, 1'b0);
    chk("rst_data", rsp_data, '0);
    chk("rst_addr", rsp_addr, '0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    chk("rst_ready_hold", req_ready, 1'b0);
    sb.delete(); crd_m = D; live_m = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic acc;
    int n_acc, pops0;
    logic prev_v;
    logic [AW+DW-1:0] prev_w;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0; flush = 0;
    n_total = 0; n_bad = 0; n_pop = 0; crd_m = D; live_m = 0;

    // T1 initial reset; first post-release edge refuses, then fill the array
    @(negedge clk);
    do_reset();
    idle(1, 1'b1);
    for (int i = 0; i < (1 << IW); i++)
      cycle(1'b1, 1'b1, AW'(i), DW'($urandom), 1'b1, 1'b0, acc);

    // T2 streaming reads with exact latency and one response per cycle
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, AW'(i), DW'(32'h100 + i), 1'b1, 1'b0, acc);
    for (int j = 0; j < 8 + LAT + 1; j++) begin
      chk("t2_vld", rsp_valid, (j >= LAT + 1) && (j < 8 + LAT + 1));
      if (rsp_valid) chk("t2_data", rsp_data, DW'(32'h100 + j - LAT - 1));
      cycle(j < 8, 1'b0, AW'(j), '0, 1'b1, 1'b0, acc);
    end
    drain();

    // T3 backpressure: only D reads fit, head holds stable
    n_acc = 0; prev_v = 0; prev_w = '0;
    for (int i = 0; i < 6; i++) begin
      if (prev_v) begin
        chk("t3_vld_hold", rsp_valid, 1'b1);
        chk("t3_hold", {rsp_addr, rsp_data}, prev_w);
      end
      prev_v = rsp_valid; prev_w = {rsp_addr, rsp_data};
      cycle(1'b1, 1'b0, AW'(16 + i), '0, 1'b0, 1'b0, acc);
      n_acc += int'(acc);
    end
    idle(3, 1'b0);
    chk("t3_hold_end", {rsp_addr, rsp_data}, sb[0]);
    chk("t3_acc", n_acc, 4);
    pops0 = n_pop;
    drain();
    chk("t3_pops", n_pop - pops0, 4);

    // T4 read-after-write and index aliasing
    cycle(1'b1, 1'b1, AW'(5), DW'(32'hABC), 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, AW'(5), '0, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, AW'(5 + (1 << IW)), '0, 1'b1, 1'b0, acc);
    for (int i = 0; i < LAT + 1; i++) begin
      if (rsp_valid) chk("t4_data", rsp_data, DW'(32'hABC));
      idle(1, 1'b1);
    end
    drain();

    // T5 flush with a same-edge read
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b0, AW'(16'h20), '0, 1'b0, 1'b1, acc);
    pops0 = n_pop;
    for (int i = 0; i < LAT + 1; i++) begin
      if (rsp_valid) chk("t5_addr", rsp_addr, AW'(16'h20));
      idle(1, 1'b1);
    end
    drain();
    chk("t5_pops", n_pop - pops0, 1);
    chk("t5_busy", busy, 1'b0);

    // T1 reset mid-traffic: in-flight reads vanish
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, AW'(40 + i), '0, 1'b0, 1'b0, acc);
    do_reset();
    idle(1, 1'b1);
    pops0 = n_pop;
    idle(LAT + 3, 1'b1);
    chk("t1_no_rsp", n_pop - pops0, 0);
    cycle(1'b1, 1'b0, AW'(7), '0, 1'b1, 1'b0, acc);
    drain();

    // T6 random mix against the model
    for (int i = 0; i < 10000; i++)
      cycle(($urandom % 4) != 0, ($urandom % 10) < 3, AW'($urandom), DW'($urandom),
            ($urandom % 10) < 7, ($urandom % 50) == 0, acc);
    drain();
    chk("t6_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
